// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and default line parameters
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

  localparam int DEFAULT_BAUD_RATE  = 115_200;
  localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_os_tick.sv
// rtl/uart_os_tick.sv - oversample tick divider with phase-restart clear
module uart_os_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] tick_cnt;

  assign tick = !clear && (tick_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (clear || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receiver, LSB-first, one-cycle valid/error strobes
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_receiver: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 2");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
    $error("uart_receiver: OVERSAMPLE must be even and >= 8");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bits_check
    $error("uart_receiver: DATA_BITS must be 5..9");
  end

  logic                 rx_meta, rx_s;
  uart_state_e          state, next_state;
  logic                 tick, tick_clear;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 os_mid, os_last;
  logic                 sample, valid_d, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Phase is held in IDLE/WAIT_HIGH so the first tick lands DIV clks after the start edge.
  assign tick_clear = (state == IDLE) || (state == WAIT_HIGH);

  uart_os_tick #(.DIV(DIV)) u_os_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .tick  (tick)
  );

  assign os_mid  = tick && (os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
  assign os_last = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    sample     = 1'b0;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) next_state = START;
      end
      START: begin
        if (os_mid) next_state = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (os_last) begin
          sample = 1'b1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) next_state = STOP;
        end
      end
      STOP: begin
        if (os_last) begin
          if (rx_s) begin
            valid_d    = 1'b1;
            next_state = IDLE;
          end else begin
            err_d      = 1'b1;
            next_state = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (next_state != state) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= os_last ? '0 : os_cnt + 1'b1;
      end

      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (sample) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      // Line order is LSB first, so each new bit enters at the top and drifts down.
      if (sample) shift <= {rx_s, shift[DATA_BITS-1:1]};
      if (valid_d) rx_data <= shift;

      rx_valid  <= valid_d;
      frame_err <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized and directed self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int BIT_CLKS = 160;
  localparam int LATENCY  = 1520;
  localparam int TOL      = 3;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int busy_cyc = 0;
  int excl_bad = 0;
  logic prev_pulse = 1'b0;

  int ev_kind[$];
  int ev_cyc[$];

  logic [7:0] exp_data;
  int         exp_events;

  uart_receiver #(
    .CLK_FREQ   (1_600_000),
    .BAUD_RATE  (10_000),
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      ev_kind.push_back(0);
      ev_cyc.push_back(cyc);
    end
    if (frame_err) begin
      ev_kind.push_back(1);
      ev_cyc.push_back(cyc);
    end
    if ((rx_valid && frame_err) || (prev_pulse && (rx_valid || frame_err))) excl_bad++;
    prev_pulse = rx_valid || frame_err;
    if (busy) busy_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input logic stop);
    int t0;
    int base;
    int d;
    base = ev_kind.size();
    send_frame(b, stop, t0);
    exp_events++;
    chk({tag, " events"}, ev_kind.size() - base, 1);
    if (ev_kind.size() > base) begin
      chk({tag, " kind"}, ev_kind[base], stop ? 0 : 1);
      d = ev_cyc[base] - t0;
      chk({tag, " latency"}, (d >= LATENCY - TOL && d <= LATENCY + TOL) ? LATENCY : d, LATENCY);
    end
    if (stop) exp_data = b;
    chk({tag, " rx_data"}, rx_data, exp_data);
  endtask

  initial begin
    int base;
    int b0;
    int gap;
    int t0;
    logic [7:0] rb;
    logic       rs;

    exp_data   = 8'h00;
    exp_events = 0;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset rx_data", rx_data, 0);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset busy", busy, 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle busy count", busy_cyc, 0);

    run_frame("a5", 8'hA5, 1'b1);
    repeat (100) @(negedge clk);

    base = ev_kind.size();
    b0   = busy_cyc;
    rx   = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch busy seen", (busy_cyc - b0) > 0, 1);
    chk("glitch busy end", busy, 0);
    chk("glitch events", ev_kind.size() - base, 0);

    run_frame("3c_err", 8'h3C, 1'b0);
    base = ev_kind.size();
    repeat (5 * BIT_CLKS) @(negedge clk);
    chk("break no retrigger", ev_kind.size() - base, 0);
    chk("break busy", busy, 1);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    chk("break released busy", busy, 0);
    run_frame("55", 8'h55, 1'b1);
    repeat (60) @(negedge clk);

    base = ev_kind.size();
    run_frame("b2b_00", 8'h00, 1'b1);
    run_frame("b2b_ff", 8'hFF, 1'b1);
    if (ev_kind.size() >= base + 2)
      chk("b2b spacing", ev_cyc[base+1] - ev_cyc[base], 1600);
    else
      chk("b2b pulse count", ev_kind.size() - base, 2);
    repeat (60) @(negedge clk);

    base = ev_kind.size();
    t0   = cyc;
    rx   = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rb = 8'h7E;
      rx = rb[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rst = 1'b1;
    rx  = 1'b1;
    exp_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("midreset events", ev_kind.size() - base, 0);
    chk("midreset busy", busy, 0);
    chk("midreset rx_data", rx_data, 0);
    run_frame("81", 8'h81, 1'b1);

    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rnd%0d", i), rb, rs);
      rx  = 1'b1;
      gap = rs ? $urandom_range(0, 200) : $urandom_range(20, 200);
      repeat (gap) @(negedge clk);
    end
    repeat (200) @(negedge clk);

    chk("total events", ev_kind.size(), exp_events);
    chk("pulse exclusivity", excl_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
